// File: rtl/hazard_fwd_unit_pkg.sv
// cpu_pipe_pkg: scoreboard entry type and slot/select constants shared by the hazard unit.
package cpu_pipe_pkg;
    localparam int MAX_AW = 8;
    localparam int SLOT_EX = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB = 2;
    localparam int FWD_SEL_RF = 0;
    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              wen;
        logic              load;
    } entry_t;
endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// fwd_select: picks the youngest in-flight producer of one source register and muxes its data.
module fwd_select
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AW = 4,
    parameter int DEPTH = 3,
    parameter int R0_ZERO = 1,
    parameter int SW = $clog2(DEPTH + 1)
) (
    input  entry_t [DEPTH-1:0]        tbl,
    input  logic [AW-1:0]             src,
    input  logic                      use_src,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    input  logic [DATA_W-1:0]         rf_data,
    output logic [SW-1:0]             sel,
    output logic [DATA_W-1:0]         data,
    output logic                      load_hit
);
    logic [DEPTH-1:0] match;
    logic src_ok;
    assign src_ok = use_src && !(R0_ZERO != 0 && src == '0);
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            match[k] = src_ok && tbl[k].valid && tbl[k].wen && tbl[k].rd == MAX_AW'(src);
    end
    assign load_hit = match[SLOT_EX] && tbl[SLOT_EX].load;
    // A load still in EX has no data yet, so it is skipped as a source.
    always_comb begin
        sel = SW'(FWD_SEL_RF);
        data = rf_data;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (match[k] && !(k == SLOT_EX && tbl[k].load)) begin
                sel = SW'(k + 1);
                data = stage_data[k*DATA_W +: DATA_W];
            end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-driven operand forwarding, load-use stall and branch flush.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/forward performance counters.
module hazard_fwd_unit
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG = 16,
    parameter int DEPTH = 3,
    parameter int R0_ZERO = 1,
    localparam int AW = $clog2(NREG),
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    id_valid,
    input  logic [AW-1:0]           id_rs,
    input  logic [AW-1:0]           id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic [AW-1:0]           id_rd,
    input  logic                    id_wen,
    input  logic                    id_load,
    input  logic                    br_taken,
    input  logic                    ext_stall,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic [DATA_W-1:0]       rf_rs_data,
    input  logic [DATA_W-1:0]       rf_rt_data,
    output logic [SW-1:0]           fwd_a_sel,
    output logic [SW-1:0]           fwd_b_sel,
    output logic [DATA_W-1:0]       fwd_a_data,
    output logic [DATA_W-1:0]       fwd_b_data,
    output logic                    stall_if_id,
    output logic                    bubble_id_ex,
    output logic                    flush_if_id
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]             perf_stalls,
    output logic [31:0]             perf_flushes,
    output logic [31:0]             perf_fwds
`endif
);
    entry_t [DEPTH-1:0] tbl;
    entry_t id_entry;
    logic a_lh, b_lh, load_use;
    fwd_select #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .SW(SW)) u_fwd_a (
        .tbl(tbl), .src(id_rs), .use_src(id_use_rs), .stage_data(stage_data),
        .rf_data(rf_rs_data), .sel(fwd_a_sel), .data(fwd_a_data), .load_hit(a_lh)
    );
    fwd_select #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .SW(SW)) u_fwd_b (
        .tbl(tbl), .src(id_rt), .use_src(id_use_rt), .stage_data(stage_data),
        .rf_data(rf_rt_data), .sel(fwd_b_sel), .data(fwd_b_data), .load_hit(b_lh)
    );
    assign load_use = id_valid && (a_lh || b_lh);
    // ext_stall masks the branch; EX keeps br_taken up until the pipeline moves again.
    assign flush_if_id = br_taken && !ext_stall;
    assign bubble_id_ex = flush_if_id || load_use;
    assign stall_if_id = ext_stall || (load_use && !br_taken);
    assign id_entry = (id_valid && !bubble_id_ex)
                    ? entry_t'{valid: 1'b1, rd: MAX_AW'(id_rd), wen: id_wen, load: id_load}
                    : '0;
    always_ff @(posedge Clk)
        if (!Rst) tbl <= '0;
        else if (!ext_stall) tbl <= {tbl[DEPTH-2:0], id_entry};
`ifdef HAZARD_PERF_CNT_EN
    logic inc_stall, inc_flush, inc_fwd;
    assign inc_stall = load_use && !br_taken && !ext_stall;
    assign inc_flush = flush_if_id;
    assign inc_fwd = (fwd_a_sel != '0) || (fwd_b_sel != '0);
    always_ff @(posedge Clk)
        if (!Rst) begin
            perf_stalls <= '0;
            perf_flushes <= '0;
            perf_fwds <= '0;
        end else begin
            perf_stalls <= perf_stalls + 32'(inc_stall && !(&perf_stalls));
            perf_flushes <= perf_flushes + 32'(inc_flush && !(&perf_flushes));
            perf_fwds <= perf_fwds + 32'(inc_fwd && !(&perf_fwds));
        end
`endif
endmodule
